user_apb_initiator: RTL and testbench
=====================================

# user_apb_initiator

APB4 requester that converts a simple valid/ready request/response port into single APB4 transfers with SETUP and ACCESS phases. It drives the `apb4_if` bus toward `user_ip_design`-style APB4 slaves, so user logic or a test sequencer can issue register reads and writes without hand-coding APB phases. It allows one outstanding transfer, holds the response until it is consumed, and has a programmable PREADY-stall timeout.

## Interface
Parameters:
- `TIMEOUT`, default 16: number of consecutive ACCESS cycles with `pready`=0 before the transfer is aborted; 0 disables the timeout.
- `AW`, default 32: request address width; zero-extended onto `paddr`.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: request accepted when valid and ready are both 1.
- `req_write_i`, in, 1: 1 = write, 0 = read.
- `req_addr_i`, in, AW: byte address.
- `req_wdata_i`, in, 32: write data.
- `req_wstrb_i`, in, 4: write byte strobes.
- `req_prot_i`, in, 3: value driven on `pprot`.
- `rsp_valid_o`, out, 1: response valid.
- `rsp_ready_i`, in, 1: response consumed when valid and ready are both 1.
- `rsp_rdata_o`, out, 32: read data; 0 for writes and for timeouts.
- `rsp_err_o`, out, 2: response code: 00 OK, 01 SLVERR, 10 TIMEOUT.
- `apb`, `apb4_if.master`: `paddr`, `pprot`, `psel`, `penable`, `pwrite`, `pwdata`, `pstrb`, `pready`, `prdata`, `pslverr`.

## Operation
- The FSM has three states: IDLE, SETUP, ACCESS.
- `req_ready_o` = (state==IDLE) && (!`rsp_valid_o` || `rsp_ready_i`).
- IDLE → SETUP on request handshake.
  - On that handshake, register `paddr`, `pwrite`, `pwdata`, `pprot` and `pstrb`.
  - `pstrb` is forced to 0 for reads.
- SETUP: `psel`=1, `penable`=0, lasting exactly one cycle, then → ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - `pready`=1 → capture the response, set `rsp_valid_o`, return to IDLE.
    - `rsp_err_o` = `pslverr` ? 01 : 00.
    - `rsp_rdata_o` = `prdata` for reads, 0 for writes.
    - `prdata` is returned even when `pslverr`=1.
  - `pready`=0 → the stall counter increments.
    - The counter reaches `TIMEOUT` when `TIMEOUT`≠0: drop `psel`/`penable`, respond with 10 and rdata 0, go to IDLE.
- The stall counter is 8 bits and clears on entering SETUP. It saturates and never wraps.
- A `TIMEOUT` value greater than 255 is a parameter error, caught by an elaboration-time assertion.
- `paddr`/`pwrite`/`pwdata`/`pstrb`/`pprot` hold their values from SETUP through the final ACCESS cycle. They keep their last values in IDLE.
- The response registers hold stable while `rsp_valid_o`=1 && !`rsp_ready_i`.
- Same-cycle response handshake and new request acceptance are allowed.

## Timing
- Reset values of all outputs:
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `pprot`: 0.
  - `req_ready_o`: 1.
  - `rsp_valid_o`: 0; `rsp_rdata_o`: 0; `rsp_err_o`: 00.
- Request accepted at edge N → SETUP in cycle N+1 → ACCESS in cycle N+2.
  - With zero wait states, `rsp_valid_o` rises in cycle N+3.
  - Each wait state adds one cycle.
- Peak throughput is one transfer per 3 cycles, reached when `rsp_ready_i` is held at 1.
- Timeout: `psel` falls in the cycle after the TIMEOUT-th stalled ACCESS cycle, in the same cycle `rsp_valid_o` rises.
- Reset mid-transfer:
  - `psel`/`penable` drop asynchronously and the FSM returns to IDLE.
  - Any pending response is discarded; no response is issued for the aborted transfer.
- `req_*` inputs are ignored outside handshake cycles.
- `pready` and `pslverr` are ignored outside ACCESS.

## Structure
- Package `user_apb_init_pkg`:
  - `apb_init_state_e`: IDLE, SETUP, ACCESS.
  - `apb_rsp_err_e`: OK=2'b00, SLVERR=2'b01, TIMEOUT=2'b10.
  - Localparam `APB_STALL_CW` = 8.
- Sub-module `user_apb_stall_cnt`:
  - A saturating counter with a clear input and an enable input.
  - Outputs a `hit` flag when the count equals `TIMEOUT` and `TIMEOUT`≠0.
- All remaining registers live in `user_apb_initiator`.

## Test plan
- Zero-wait write:
  - Stimulus: addr 0x04, wdata 0x0000_0055, wstrb 0xF.
  - Required: SETUP at N+1 and ACCESS at N+2 with `pstrb`=0xF; response at N+3 with err 00, rdata 0.
- Read with 3 wait states:
  - Stimulus: read addr 0x00; slave returns `prdata`=0x0000_00FF.
  - Required: ACCESS lasts 4 cycles; response rdata 0x0000_00FF, err 00; `pstrb`=0 throughout.
- Slave error:
  - Stimulus: read with `pslverr`=1 and `prdata`=0x1234.
  - Required: err 01, rdata 0x1234; FSM returns to IDLE.
- Timeout:
  - Stimulus: TIMEOUT=4 with `pready` held at 0.
  - Required: exactly 4 ACCESS cycles; then `psel`=0, err 10, rdata 0; the next request is accepted afterwards.
- Back-to-back with backpressure:
  - Stimulus: two requests queued; `rsp_ready_i`=0 for 5 cycles after the first response.
  - Required: the second request is not accepted and the response stays stable. Once `rsp_ready_i`=1, the second request is accepted in that same cycle.
- Reset mid-transfer:
  - Stimulus: assert `rst_i` during ACCESS.
  - Required: `psel`/`penable` fall immediately, and no response is issued. After release, `req_ready_o`=1.

Source files
------------

// File: rtl/user_apb_initiator_pkg.sv
// Shared types and constants for the APB4 requester: FSM state encoding,
// response codes and the stall counter width.
package user_apb_init_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_init_state_e;

    typedef enum logic [1:0] {
        OK      = 2'b00,
        SLVERR  = 2'b01,
        TIMEOUT = 2'b10
    } apb_rsp_err_e;

    localparam int APB_STALL_CW = 8;

endpackage

// File: rtl/user_apb_initiator_if.sv
// APB4 bus bundle between one requester (master) and one completer (slave).
interface apb4_if;

    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/user_apb_stall_cnt.sv
// Saturating PREADY-stall counter; hit fires on the stalled cycle whose
// increment brings the count to TIMEOUT (never when TIMEOUT is 0).
module user_apb_stall_cnt
    import user_apb_init_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CNT_MAX = (1 << APB_STALL_CW) - 1;

    if (TIMEOUT < 0 || TIMEOUT > CNT_MAX) begin : g_bad_timeout
        $error("user_apb_stall_cnt: TIMEOUT must be in 0..255");
    end

    localparam logic [APB_STALL_CW-1:0] LIMIT = APB_STALL_CW'(TIMEOUT);
    localparam logic [APB_STALL_CW-1:0] SAT   = '1;

    logic [APB_STALL_CW-1:0] count;
    logic [APB_STALL_CW-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (en && count != SAT) begin
            count_next = count + APB_STALL_CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign hit = (TIMEOUT != 0) && en && !clr && (count_next == LIMIT);

endmodule

// File: rtl/user_apb_initiator.sv
// APB4 requester: turns one valid/ready request into a SETUP+ACCESS transfer
// and holds the response until the user side consumes it.
module user_apb_initiator
    import user_apb_init_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_write_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [31:0]   req_wdata_i,
    input  logic [3:0]    req_wstrb_i,
    input  logic [2:0]    req_prot_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic [1:0]    rsp_err_o,
    apb4_if.master        apb
);

    if (AW < 1 || AW > 32) begin : g_bad_aw
        $error("user_apb_initiator: AW must be in 1..32");
    end

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       req_fire;
    logic       rsp_fire;
    logic       xfer_done;
    logic       stall_en;
    logic       stall_hit;

    assign req_ready_o = (state == ST_IDLE) && (!rsp_valid_o || rsp_ready_i);
    assign req_fire    = req_valid_i && req_ready_o;
    assign rsp_fire    = rsp_valid_o && rsp_ready_i;
    assign xfer_done   = (state == ST_ACCESS) && apb.pready;
    assign stall_en    = (state == ST_ACCESS) && !apb.pready;

    // psel/penable decode straight from state so reset drops them at once
    assign apb.psel    = (state != ST_IDLE);
    assign apb.penable = (state == ST_ACCESS);

    user_apb_stall_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (req_fire),
        .en  (stall_en),
        .hit (stall_hit)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (req_fire) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (xfer_done || stall_hit) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus payload is captured once at acceptance and held through ACCESS
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            apb.paddr  <= '0;
            apb.pwrite <= 1'b0;
            apb.pwdata <= '0;
            apb.pstrb  <= '0;
            apb.pprot  <= '0;
        end else if (req_fire) begin
            apb.paddr  <= 32'(req_addr_i);
            apb.pwrite <= req_write_i;
            apb.pwdata <= req_wdata_i;
            apb.pstrb  <= req_write_i ? req_wstrb_i : 4'b0000;
            apb.pprot  <= req_prot_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= OK;
        end else if (xfer_done) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= apb.pwrite ? 32'h0 : apb.prdata;
            rsp_err_o   <= apb.pslverr ? SLVERR : OK;
        end else if (stall_hit) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= user_apb_init_pkg::TIMEOUT;
        end else if (rsp_fire) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_user_apb_initiator.sv
// Directed bench for user_apb_initiator: table of single transfers plus
// hand-written timeout, backpressure and mid-transfer reset sequences.
module tb_user_apb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    int checks = 0;
    int errors = 0;

    apb4_if apb ();

    user_apb_initiator #(
        .TIMEOUT (4),
        .AW      (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .req_prot_i  (req_prot),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .apb         (apb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  prot;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_paddr;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transfer with rsp_ready held high; pready is driven high
    // during SETUP to show it is ignored there.
    task automatic applyStimulus(input vec_t v);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        req_prot  = v.prot;
        rsp_ready = 1'b1;
        checkOutput("idle_req_ready", 32'(req_ready), 32'd1);
        checkOutput("idle_psel", 32'(apb.psel), 32'd0);
        tick();
        req_valid = 1'b0;
        req_write = ~v.write;
        req_addr  = 16'h5A5A;
        req_wdata = ~v.wdata;
        req_wstrb = ~v.wstrb;
        req_prot  = ~v.prot;
        apb.pready  = 1'b1;
        apb.pslverr = v.slverr;
        apb.prdata  = v.prdata;
        checkOutput("setup_psel", 32'(apb.psel), 32'd1);
        checkOutput("setup_penable", 32'(apb.penable), 32'd0);
        checkOutput("setup_paddr", apb.paddr, v.exp_paddr);
        checkOutput("setup_pwrite", 32'(apb.pwrite), 32'(v.write));
        checkOutput("setup_pwdata", apb.pwdata, v.wdata);
        checkOutput("setup_pstrb", 32'(apb.pstrb), 32'(v.exp_pstrb));
        checkOutput("setup_pprot", 32'(apb.pprot), 32'(v.prot));
        checkOutput("setup_req_ready", 32'(req_ready), 32'd0);
        tick();
        for (int w = 0; w <= v.waits; w++) begin
            checkOutput("access_psel", 32'(apb.psel), 32'd1);
            checkOutput("access_penable", 32'(apb.penable), 32'd1);
            checkOutput("access_paddr", apb.paddr, v.exp_paddr);
            checkOutput("access_pstrb", 32'(apb.pstrb), 32'(v.exp_pstrb));
            checkOutput("access_rsp_valid", 32'(rsp_valid), 32'd0);
            apb.pready = (w == v.waits);
            tick();
        end
        apb.pready = 1'b0;
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        checkOutput("rsp_rdata", rsp_rdata, v.exp_rdata);
        checkOutput("rsp_psel", 32'(apb.psel), 32'd0);
        tick();
        checkOutput("rsp_consumed", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0004, 32'h0000_0055, 4'hF, 3'd0, 0, 1'b0, 32'h0000_0BAD,
                    2'b00, 32'h0, 4'hF, 32'h0000_0004};
        vecs[1] = '{1'b0, 16'h0000, 32'h1111_2222, 4'hF, 3'd2, 3, 1'b0, 32'h0000_00FF,
                    2'b00, 32'h0000_00FF, 4'h0, 32'h0000_0000};
        vecs[2] = '{1'b0, 16'h0008, 32'h0, 4'h3, 3'd0, 1, 1'b1, 32'h0000_1234,
                    2'b01, 32'h0000_1234, 4'h0, 32'h0000_0008};
        vecs[3] = '{1'b1, 16'h000C, 32'hCAFE_BABE, 4'h5, 3'd7, 2, 1'b1, 32'h7777_7777,
                    2'b01, 32'h0, 4'h5, 32'h0000_000C};
        vecs[4] = '{1'b0, 16'hFFFC, 32'h0, 4'h0, 3'd1, 0, 1'b0, 32'h89AB_CDEF,
                    2'b00, 32'h89AB_CDEF, 4'h0, 32'h0000_FFFC};

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        req_prot    = '0;
        rsp_ready   = 1'b0;
        apb.pready  = 1'b0;
        apb.prdata  = '0;
        apb.pslverr = 1'b0;
        #12;
        checkOutput("rst_psel", 32'(apb.psel), 32'd0);
        checkOutput("rst_penable", 32'(apb.penable), 32'd0);
        checkOutput("rst_pwrite", 32'(apb.pwrite), 32'd0);
        checkOutput("rst_paddr", apb.paddr, 32'd0);
        checkOutput("rst_pwdata", apb.pwdata, 32'd0);
        checkOutput("rst_pstrb", 32'(apb.pstrb), 32'd0);
        checkOutput("rst_pprot", 32'(apb.pprot), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        #10;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        // Timeout: pready never rises, so the transfer aborts after 4 ACCESS cycles
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0010;
        req_wstrb = 4'hF;
        req_prot  = 3'd0;
        rsp_ready = 1'b1;
        tick();
        req_valid   = 1'b0;
        apb.pready  = 1'b0;
        apb.prdata  = 32'hDEAD_BEEF;
        apb.pslverr = 1'b1;
        checkOutput("to_setup_psel", 32'(apb.psel), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_access_penable", 32'(apb.penable), 32'd1);
            checkOutput("to_access_rsp_valid", 32'(rsp_valid), 32'd0);
            tick();
        end
        checkOutput("to_psel_dropped", 32'(apb.psel), 32'd0);
        checkOutput("to_penable_dropped", 32'(apb.penable), 32'd0);
        checkOutput("to_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("to_rsp_err", 32'(rsp_err), 32'd2);
        checkOutput("to_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("to_req_ready", 32'(req_ready), 32'd1);
        apb.pslverr = 1'b0;
        tick();
        checkOutput("to_rsp_consumed", 32'(rsp_valid), 32'd0);
        applyStimulus(vecs[0]);

        // Backpressure: second request waits until the first response is taken
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0020;
        req_wstrb = 4'h0;
        req_prot  = 3'd0;
        rsp_ready = 1'b0;
        tick();
        req_addr   = 16'h0024;
        apb.pready = 1'b1;
        tick();
        apb.prdata = 32'h0000_A5A5;
        tick();
        apb.prdata = 32'h0;
        apb.pready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_rdata", rsp_rdata, 32'h0000_A5A5);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            checkOutput("bp_psel", 32'(apb.psel), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_req_ready_release", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        checkOutput("bp_second_setup", 32'(apb.psel), 32'd1);
        checkOutput("bp_second_paddr", apb.paddr, 32'h0000_0024);
        checkOutput("bp_first_consumed", 32'(rsp_valid), 32'd0);
        tick();
        apb.pready = 1'b1;
        apb.prdata = 32'h0000_0077;
        tick();
        apb.pready = 1'b0;
        checkOutput("bp_second_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("bp_second_rdata", rsp_rdata, 32'h0000_0077);
        tick();

        // Reset during ACCESS: bus drops without waiting for a clock edge
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0030;
        req_wdata = 32'h1234_5678;
        req_wstrb = 4'hF;
        tick();
        req_valid  = 1'b0;
        apb.pready = 1'b0;
        tick();
        checkOutput("rm_access_penable", 32'(apb.penable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rm_psel_async", 32'(apb.psel), 32'd0);
        checkOutput("rm_penable_async", 32'(apb.penable), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        apb.pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rm_no_rsp", 32'(rsp_valid), 32'd0);
            checkOutput("rm_req_ready", 32'(req_ready), 32'd1);
            checkOutput("rm_psel_idle", 32'(apb.psel), 32'd0);
        end
        apb.pready = 1'b0;
        applyStimulus(vecs[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the end, got hang, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
